// File: rtl/vend_pkg.sv
// vend_pkg: shared types and helpers for the multi-product vending controller.
//   coin_e     : coin acceptor encoding (00=1, 01=2, 10=5 units, 11=illegal)
//   state_e    : controller states (IDLE, PEND, VEND)
//   coin_units : decode a coin code to its value in coin units (0 for illegal)
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_1   = 2'b00,
    COIN_2   = 2'b01,
    COIN_5   = 2'b10,
    COIN_BAD = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    VEND = 2'd2
  } state_e;

  localparam int COIN_UNITS_W = 3;

  function automatic logic [COIN_UNITS_W-1:0] coin_units(input coin_e code);
    case (code)
      COIN_1:  coin_units = 3'd1;
      COIN_2:  coin_units = 3'd2;
      COIN_5:  coin_units = 3'd5;
      default: coin_units = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_credit.sv
// vend_credit: coin credit accumulator with ceiling check.
//   clk, rst      : clock, asynchronous active-low reset
//   coin_vld/val  : one-cycle coin strobe and coin code
//   clr           : drop credit to 0 at the next edge (sale or refund)
//   eff           : combinational effective credit = credit + accepted coin
//   credit        : registered credit
//   coin_rej      : registered one-cycle pulse for an illegal or over-ceiling coin
// Without clr the register simply loads eff, so a coin arriving while the
// credit was just cleared becomes the new credit.
module vend_credit
  import vend_pkg::*;
#(
  parameter int CRED_W     = 6,
  parameter int MAX_CREDIT = 2**CRED_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_vld,
  input  logic [1:0]        coin_val,
  input  logic              clr,
  output logic [CRED_W:0]   eff,
  output logic [CRED_W-1:0] credit,
  output logic              coin_rej
);

  logic [CRED_W:0] sum;
  logic            take;

  // NOTE: every signal written here gets a value on every path, otherwise
  // synthesis infers a latch to hold the old value.
  always_comb begin
    sum  = {1'b0, credit} + (CRED_W+1)'(coin_units(coin_e'(coin_val)));
    take = coin_vld && (coin_e'(coin_val) != COIN_BAD) &&
           (sum <= (CRED_W+1)'(MAX_CREDIT));
    eff  = take ? sum : {1'b0, credit};
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit   <= '0;
      coin_rej <= 1'b0;
    end else begin
      credit   <= clr ? '0 : eff[CRED_W-1:0];
      coin_rej <= coin_vld && !take;
    end
  end

endmodule

// File: rtl/vend_multi.sv
// vend_multi: parametrised multi-product vending controller.
//   clk, rst                 : clock, asynchronous active-low reset
//   coin_vld, coin_val       : coin strobe and code (see vend_pkg::coin_e)
//   sel_vld, sel_idx         : product selection strobe and index
//   cancel                   : refund request (beats a same-cycle selection)
//   restock_vld/idx/cnt      : load a stock counter (VEND_STOCK_EN only)
//   dispense                 : one-hot one-cycle dispense pulse
//   change_vld, change       : one-cycle change/refund strobe and amount
//   coin_rej, sel_rej        : one-cycle rejection pulses
//   credit                   : registered credit
//   busy                     : high while a selection waits for credit (PEND)
// Build option: define VEND_STOCK_EN to add per-item stock counters; without
// it the restock ports are ignored and stock is unlimited.
// The sale decision is taken at the edge that samples the qualifying coin or
// selection; dispense/change are registered on that edge and the FSM spends
// that visible pulse cycle in VEND, then returns to IDLE.
module vend_multi
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int CRED_W     = 6,
  parameter logic [0:N_ITEMS-1][CRED_W-1:0] PRICES =
    {CRED_W'(5), CRED_W'(4), CRED_W'(3), CRED_W'(2)},
  parameter int MAX_CREDIT = 2**CRED_W - 1,
  parameter int STOCK_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coin_vld,
  input  logic [1:0]                 coin_val,
  input  logic                       sel_vld,
  input  logic [$clog2(N_ITEMS)-1:0] sel_idx,
  input  logic                       cancel,
  input  logic                       restock_vld,
  input  logic [$clog2(N_ITEMS)-1:0] restock_idx,
  input  logic [STOCK_W-1:0]         restock_cnt,
  output logic [N_ITEMS-1:0]         dispense,
  output logic                       change_vld,
  output logic [CRED_W-1:0]          change,
  output logic                       coin_rej,
  output logic                       sel_rej,
  output logic [CRED_W-1:0]          credit,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_ITEMS);

  state_e            state;
  logic [IDX_W-1:0]  item_q;
  logic [CRED_W:0]   eff;
  logic              clr;

  logic              active;
  logic              sel_in_range;
  logic              sel_stock_ok;
  logic              item_stock_ok;
  logic              do_cancel;
  logic              sel_ok;
  logic              sel_bad;
  logic              do_vend;
  logic [IDX_W-1:0]  tgt_item;
  logic [CRED_W-1:0] tgt_price;

  vend_credit #(
    .CRED_W     (CRED_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit (
    .clk      (clk),
    .rst      (rst),
    .coin_vld (coin_vld),
    .coin_val (coin_val),
    .clr      (clr),
    .eff      (eff),
    .credit   (credit),
    .coin_rej (coin_rej)
  );

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock [N_ITEMS];

  assign sel_stock_ok  = (stock[sel_idx] != '0);
  assign item_stock_ok = (stock[item_q] != '0);

  // NOTE: the stock array is reset element by element because an empty
  // machine must refuse every sale until it is restocked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= '0;
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        // A restock landing on the item being sold overrides the decrement.
        if (restock_vld && (int'(restock_idx) == i))
          stock[i] <= restock_cnt;
        else if (do_vend && (int'(tgt_item) == i))
          stock[i] <= stock[i] - STOCK_W'(1);
      end
    end
  end
`else
  logic unused_restock;

  assign sel_stock_ok   = 1'b1;
  assign item_stock_ok  = 1'b1;
  assign unused_restock = ^{restock_vld, restock_idx, restock_cnt};
`endif

  // Decision for this cycle: cancel first, then a (possibly new) target item
  // is sold if the effective credit covers its price.
  always_comb begin
    active       = (state == IDLE) || (state == PEND);
    sel_in_range = (int'(sel_idx) < N_ITEMS);
    do_cancel    = active && cancel;
    sel_ok       = active && !cancel && sel_vld && sel_in_range && sel_stock_ok;
    sel_bad      = active && !cancel && sel_vld && !(sel_in_range && sel_stock_ok);
    tgt_item     = sel_ok ? sel_idx : item_q;
    tgt_price    = PRICES[tgt_item];
    do_vend      = active && !cancel && (sel_ok || (state == PEND)) &&
                   (sel_ok || item_stock_ok) &&
                   (eff >= {1'b0, tgt_price});
    clr          = do_cancel || do_vend;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      item_q     <= '0;
      dispense   <= '0;
      change_vld <= 1'b0;
      change     <= '0;
      sel_rej    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dispense   <= '0;
      change_vld <= 1'b0;
      change     <= '0;
      sel_rej    <= sel_bad;
      busy       <= 1'b0;
      case (state)
        IDLE, PEND: begin
          if (do_cancel) begin
            state <= IDLE;
            if (eff != '0) begin
              change_vld <= 1'b1;
              change     <= eff[CRED_W-1:0];
            end
          end else if (do_vend) begin
            state      <= VEND;
            dispense   <= N_ITEMS'(1) << tgt_item;
            change_vld <= 1'b1;
            // eff >= price here, so the difference always fits CRED_W bits.
            change     <= eff[CRED_W-1:0] - tgt_price;
          end else if (sel_ok) begin
            state  <= PEND;
            item_q <= sel_idx;
            busy   <= 1'b1;
          end else begin
            busy <= (state == PEND);
          end
        end
        VEND:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_multi.sv
// tb_vend_multi: self-checking bench for vend_multi. A behavioural model of
// the vending rules (integer credit, pending item, stock array) predicts every
// registered output each cycle; directed sequences are followed by random
// traffic and an asynchronous reset taken mid-run.
module tb_vend_multi;

  localparam int N    = 4;
  localparam int CW   = 6;
  localparam int MAXC = 63;
  localparam int SW   = 4;
`ifdef VEND_STOCK_EN
  localparam bit STOCK = 1'b1;
`else
  localparam bit STOCK = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          coin_vld;
  logic [1:0]    coin_val;
  logic          sel_vld;
  logic [1:0]    sel_idx;
  logic          cancel;
  logic          restock_vld;
  logic [1:0]    restock_idx;
  logic [SW-1:0] restock_cnt;
  logic [N-1:0]  dispense;
  logic          change_vld;
  logic [CW-1:0] change;
  logic          coin_rej;
  logic          sel_rej;
  logic [CW-1:0] credit;
  logic          busy;

  vend_multi #(.N_ITEMS(N), .CRED_W(CW), .STOCK_W(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_vld    (coin_vld),
    .coin_val    (coin_val),
    .sel_vld     (sel_vld),
    .sel_idx     (sel_idx),
    .cancel      (cancel),
    .restock_vld (restock_vld),
    .restock_idx (restock_idx),
    .restock_cnt (restock_cnt),
    .dispense    (dispense),
    .change_vld  (change_vld),
    .change      (change),
    .coin_rej    (coin_rej),
    .sel_rej     (sel_rej),
    .credit      (credit),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int price [N] = '{5, 4, 3, 2};
  int m_credit, m_pend, m_stock [N];
  bit m_vend;
  int e_disp, e_cv, e_chg, e_crej, e_srej, e_busy;
  int n_checks, n_fail, cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int units(input int code);
    case (code)
      0:       return 1;
      1:       return 2;
      2:       return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_credit = 0; m_pend = -1; m_vend = 1'b0;
    for (int i = 0; i < N; i++) m_stock[i] = 0;
    e_disp = 0; e_cv = 0; e_chg = 0; e_crej = 0; e_srej = 0; e_busy = 0;
  endtask

  task automatic model_step(input bit cv, input int cval, input bit sv, input int sidx,
                            input bit can, input bit rv, input int ridx, input int rcnt);
    int eff, tgt;
    e_disp = 0; e_cv = 0; e_chg = 0; e_crej = 0; e_srej = 0;
    eff = m_credit;
    if (cv) begin
      if (cval != 3 && m_credit + units(cval) <= MAXC) eff = m_credit + units(cval);
      else e_crej = 1;
    end
    if (m_vend) begin
      m_vend   = 1'b0;
      m_credit = eff;
    end else if (can) begin
      if (eff > 0) begin e_cv = 1; e_chg = eff; end
      m_credit = 0;
      m_pend   = -1;
    end else begin
      tgt = m_pend;
      if (sv) begin
        if (sidx < N && (!STOCK || m_stock[sidx] > 0)) tgt = sidx;
        else e_srej = 1;
      end
      if (tgt >= 0 && eff >= price[tgt] && (!STOCK || m_stock[tgt] > 0)) begin
        e_disp   = 1 << tgt;
        e_cv     = 1;
        e_chg    = eff - price[tgt];
        m_credit = 0;
        m_pend   = -1;
        m_vend   = 1'b1;
        if (STOCK) m_stock[tgt]--;
      end else begin
        m_credit = eff;
        m_pend   = tgt;
      end
    end
    if (STOCK && rv && ridx < N) m_stock[ridx] = rcnt;
    e_busy = (m_pend >= 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("dispense",   32'(dispense),   32'(e_disp));
    check("change_vld", 32'(change_vld), 32'(e_cv));
    check("change",     32'(change),     32'(e_chg));
    check("coin_rej",   32'(coin_rej),   32'(e_crej));
    check("sel_rej",    32'(sel_rej),    32'(e_srej));
    check("credit",     32'(credit),     32'(m_credit));
    check("busy",       32'(busy),       32'(e_busy));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input bit cv, input int cval, input bit sv, input int sidx,
                       input bit can, input bit rv, input int ridx, input int rcnt);
    coin_vld    = cv;  coin_val    = 2'(cval);
    sel_vld     = sv;  sel_idx     = 2'(sidx);
    cancel      = can;
    restock_vld = rv;  restock_idx = 2'(ridx); restock_cnt = SW'(rcnt);
    model_step(cv, cval, sv, sidx, can, rv, ridx, rcnt);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic coin(input int cval);  cycle(1, cval, 0, 0, 0, 0, 0, 0); endtask
  task automatic sel(input int idx);    cycle(0, 0, 1, idx, 0, 0, 0, 0);  endtask
  task automatic do_cancel();           cycle(0, 0, 0, 0, 1, 0, 0, 0);    endtask
  task automatic idle();                cycle(0, 0, 0, 0, 0, 0, 0, 0);    endtask
  task automatic restock(input int idx, input int cnt); cycle(0, 0, 0, 0, 0, 1, idx, cnt); endtask

  task automatic apply_reset();
    coin_vld = 0; coin_val = 0; sel_vld = 0; sel_idx = 0; cancel = 0;
    restock_vld = 0; restock_idx = 0; restock_cnt = 0;
    rst = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    idle();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b0;
    coin_vld = 0; coin_val = 0; sel_vld = 0; sel_idx = 0; cancel = 0;
    restock_vld = 0; restock_idx = 0; restock_cnt = 0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    idle();

    if (STOCK) for (int i = 0; i < N; i++) restock(i, 15);

    // Coins 2 + 2, then item 1 (price 4): exact sale.
    coin(1); coin(1);
    sel(1);
    check("tp1 dispense", 32'(dispense), 32'b0010);
    check("tp1 change",   32'(change),   0);
    idle();

    // Item 0 (price 5) with no credit waits; a coin of 5 completes it; a
    // coin during the vend cycle becomes the new credit.
    sel(0);
    check("tp2 busy", 32'(busy), 1);
    coin(2);
    check("tp2 dispense", 32'(dispense), 32'b0001);
    check("tp2 change",   32'(change),   0);
    coin(0);
    check("tp2 credit", 32'(credit), 1);
    do_cancel();
    check("tp2 refund", 32'(change), 1);

    // Build credit 62, a coin of 5 is returned, then refund everything.
    for (int i = 0; i < 12; i++) coin(2);
    coin(1);
    check("tp3 credit62", 32'(credit), 62);
    coin(2);
    check("tp3 coin_rej", 32'(coin_rej), 1);
    check("tp3 credit_kept", 32'(credit), 62);
    do_cancel();
    check("tp3 change_vld", 32'(change_vld), 1);
    check("tp3 change", 32'(change), 62);
    check("tp3 credit0", 32'(credit), 0);
    coin(3);
    check("tp3 bad_coin", 32'(coin_rej), 1);

    // Same-cycle coin of 2 and item 3 (price 2).
    cycle(1, 1, 1, 3, 0, 0, 0, 0);
    check("tp4 dispense", 32'(dispense), 32'b1000);
    idle();
    // Same-cycle cancel and selection: refund only.
    coin(0);
    cycle(0, 0, 1, 0, 1, 0, 0, 0);
    check("tp4 refund_only", 32'(dispense), 0);
    check("tp4 refund", 32'(change), 1);
    idle();

    // Change returned on overpay: credit 7 buys item 2 (price 3).
    coin(2); coin(1);
    sel(2);
    check("tp5 change4", 32'(change), 4);
    idle();

    // Reset in the middle of a pending sale drops everything silently.
    coin(0); sel(0);
    apply_reset();

    if (STOCK) begin
      restock(2, 1);
      coin(1); coin(0);
      sel(2);
      check("st first", 32'(dispense), 32'b0100);
      coin(1); coin(0);
      sel(2);
      check("st sel_rej", 32'(sel_rej), 1);
      check("st credit", 32'(credit), 3);
      do_cancel();
      for (int i = 0; i < N; i++) restock(i, 8);
    end

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        apply_reset();
        if (STOCK) for (int k = 0; k < N; k++) restock(k, 15);
      end
      cycle($urandom_range(99) < 40, int'($urandom_range(3)),
            $urandom_range(99) < 15, int'($urandom_range(3)),
            $urandom_range(99) < 5,
            $urandom_range(99) < 4, int'($urandom_range(3)),
            int'($urandom_range(2**SW - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
